pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline control unit that drives the hold-flag protocol consumed by the pc, if_id and id_ex stage registers. It is the producer end of that protocol.
- Arbitrates four sources into one hold level plus one PC redirect per cycle:
  - EX redirects (branch/jump)
  - EX multi-cycle busy
  - load-use hazards between ID and EX
  - an external bus-master request, which drains the pipeline before granting the bus.

Parameters:
DRAIN_CYCLES, 2, non-busy cycles spent in DRAIN before bus_gnt_o asserts (1..15)
CNT_W, 32, width of stall performance counter

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
jump_req_i  input  1  EX requests PC redirect this cycle
jump_addr_i  input  32  EX redirect target
ex_busy_i  input  1  EX executing multi-cycle op (div); EX re-issues via jump_req_i on completion
ex_is_load_i  input  1  instruction in EX is a load
ex_rd_addr_i  input  5  destination reg of instruction in EX
id_rs1_re_i  input  1  ID instruction reads rs1
id_rs2_re_i  input  1  ID instruction reads rs2
id_rs1_addr_i  input  5  ID rs1 address
id_rs2_addr_i  input  5  ID rs2 address
id_inst_addr_i  input  32  address of instruction in ID
bus_req_i  input  1  external master (debug/DMA) requests bus ownership
bus_gnt_o  output  1  bus granted, registered
hold_flag_o  output  3  hold level, `Hold_Flag_Bus: Hold_None=0, Hold_Pc=1, Hold_If=2, Hold_Id=3
jump_flag_o  output  1  PC redirect, same cycle
jump_addr_o  output  32  redirect target
stall_cnt_o  output  CNT_W  count of cycles with hold_flag_o != Hold_None, saturating

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high; ports are named clk and rst.
- Reset values: state=RUN, drain counter=0, bus_gnt_o=0, stall_cnt_o=0. While rst is high, hold_flag_o=Hold_None, jump_flag_o=0 and jump_addr_o=0.
- Hold protocol levels:
  - Hold_Pc freezes the PC.
  - Hold_If additionally flushes if_id to NOP.
  - Hold_Id additionally flushes id_ex to NOP.
  - jump_flag_o overrides the PC hold at the pc register.
- load_use = ex_is_load_i & (ex_rd_addr_i!=0) & ((id_rs1_re_i & id_rs1_addr_i==ex_rd_addr_i) | (id_rs2_re_i & id_rs2_addr_i==ex_rd_addr_i)).
- Combinational outputs in every state, in priority order:
  1. jump_req_i: jump_flag_o=1, jump_addr_o=jump_addr_i, hold=Hold_Id.
  2. ex_busy_i: hold=Hold_Id, no jump.
  3. load_use: replay, i.e. jump_flag_o=1, jump_addr_o=id_inst_addr_i, hold=Hold_Id.
  4. Otherwise hold is set by state: RUN->Hold_None, DRAIN->Hold_If, GRANT->Hold_If.
  - When jump_flag_o=0, jump_addr_o=0.
- FSM (registered, updates on rising clk):
  - RUN -> DRAIN when bus_req_i=1 and neither jump_req_i nor ex_busy_i is active. Drain counter loads 0.
  - DRAIN:
    - A cycle with jump_req_i or load_use restarts the counter at 0 (a new instruction enters the pipe).
    - A cycle with ex_busy_i freezes the counter.
    - Any other cycle increments the counter.
    - When the counter reaches DRAIN_CYCLES-1 on a qualifying increment: -> GRANT, and bus_gnt_o=1 from the next cycle.
    - bus_req_i=0 in DRAIN -> RUN, no grant issued.
  - GRANT: bus_gnt_o=1, hold=Hold_If. bus_req_i=0 -> RUN, with bus_gnt_o=0 in the same edge. The PC was held, so no replay is required.
- stall_cnt_o: increments by 1 on every clock where hold_flag_o!=Hold_None; saturates at all-ones.
- Reset mid-DRAIN or mid-GRANT: immediately RUN and bus_gnt_o=0, asynchronously.
- Latency:
  - Hold and jump outputs are zero-cycle (combinational from inputs and state).
  - Grant appears DRAIN_CYCLES+1 edges after bus_req_i is accepted in RUN, assuming no interruptions.

Test Plan:
- Reset: assert rst mid-GRANT -> bus_gnt_o=0, stall_cnt_o=0, hold_flag_o=0 without waiting for a clock edge.
- Jump: jump_req_i=1, jump_addr_i=0x0000_0100 -> same cycle jump_flag_o=1, jump_addr_o=0x100, hold_flag_o=3; stall_cnt_o increments 0->1.
- Load-use, basic: ex_is_load_i=1, ex_rd=5, id_rs2_re_i=1, id_rs2=5, id_inst_addr_i=0x24 -> jump_addr_o=0x24, hold_flag_o=3.
- Load-use, x0: same as above with ex_rd=0 -> hold_flag_o=0, jump_flag_o=0.
- Priority: jump_req_i and load_use together -> jump_addr_o=jump_addr_i. ex_busy_i held 4 cycles -> hold_flag_o=3 for 4 cycles, no jump.
- Bus drain, DRAIN_CYCLES=2: bus_req_i=1 held -> hold_flag_o=2 starting the cycle after acceptance; bus_gnt_o=1 at the 3rd edge. A jump in DRAIN delays the grant by 1 extra cycle. Dropping bus_req_i -> next edge bus_gnt_o=0, hold_flag_o=0.
- Abort: bus_req_i dropped mid-DRAIN -> RUN, bus_gnt_o never asserts.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control: arbitrates EX redirects, EX busy, load-use replays and an
// external bus request into one hold level plus one PC redirect per cycle.
module pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_req_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             ex_busy_i,
  input  logic             ex_is_load_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             id_rs1_re_i,
  input  logic             id_rs2_re_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic [31:0]      id_inst_addr_i,
  input  logic             bus_req_i,
  output logic             bus_gnt_o,
  output logic [2:0]       hold_flag_o,
  output logic             jump_flag_o,
  output logic [31:0]      jump_addr_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_IF   = 3'd2;
  localparam logic [2:0] HOLD_ID   = 3'd3;
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {RUN, DRAIN, GRANT} state_t;

  state_t     state, state_next;
  logic [3:0] drain_cnt, drain_cnt_next;
  logic       load_use;

  assign load_use = ex_is_load_i && (ex_rd_addr_i != 5'd0) &&
                    ((id_rs1_re_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                     (id_rs2_re_i && (id_rs2_addr_i == ex_rd_addr_i)));

  // Output arbitration; everything is forced quiet while reset is asserted.
  always_comb begin
    hold_flag_o = HOLD_NONE;
    jump_flag_o = 1'b0;
    jump_addr_o = 32'd0;
    if (!rst) begin
      if (jump_req_i) begin
        hold_flag_o = HOLD_ID;
        jump_flag_o = 1'b1;
        jump_addr_o = jump_addr_i;
      end else if (ex_busy_i) begin
        hold_flag_o = HOLD_ID;
      end else if (load_use) begin
        hold_flag_o = HOLD_ID;
        jump_flag_o = 1'b1;
        jump_addr_o = id_inst_addr_i;
      end else if (state != RUN) begin
        hold_flag_o = HOLD_IF;
      end
    end
  end

  // Drain counter restarts whenever a new instruction enters the pipe.
  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    case (state)
      RUN: begin
        if (bus_req_i && !jump_req_i && !ex_busy_i) begin
          state_next     = DRAIN;
          drain_cnt_next = 4'd0;
        end
      end
      DRAIN: begin
        if (!bus_req_i) begin
          state_next = RUN;
        end else if (jump_req_i || load_use) begin
          drain_cnt_next = 4'd0;
        end else if (!ex_busy_i) begin
          if (drain_cnt == DRAIN_LAST) begin
            state_next = GRANT;
          end else begin
            drain_cnt_next = drain_cnt + 4'd1;
          end
        end
      end
      GRANT: begin
        if (!bus_req_i) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= 4'd0;
      bus_gnt_o <= 1'b0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
      bus_gnt_o <= (state_next == GRANT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if ((hold_flag_o != HOLD_NONE) && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then randomized
// traffic, all compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int DRAIN_CYCLES = 2;
  localparam int CNT_W        = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             jump_req_i;
  logic [31:0]      jump_addr_i;
  logic             ex_busy_i;
  logic             ex_is_load_i;
  logic [4:0]       ex_rd_addr_i;
  logic             id_rs1_re_i;
  logic             id_rs2_re_i;
  logic [4:0]       id_rs1_addr_i;
  logic [4:0]       id_rs2_addr_i;
  logic [31:0]      id_inst_addr_i;
  logic             bus_req_i;
  logic             bus_gnt_o;
  logic [2:0]       hold_flag_o;
  logic             jump_flag_o;
  logic [31:0]      jump_addr_o;
  logic [CNT_W-1:0] stall_cnt_o;

  pipe_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
    .ex_busy_i(ex_busy_i), .ex_is_load_i(ex_is_load_i), .ex_rd_addr_i(ex_rd_addr_i),
    .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_inst_addr_i(id_inst_addr_i), .bus_req_i(bus_req_i),
    .bus_gnt_o(bus_gnt_o), .hold_flag_o(hold_flag_o),
    .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: whether the pipe is draining or granted, how many clean drain
  // cycles have elapsed, and the saturating stall total.
  bit     m_draining, m_granted;
  int     m_progress;
  longint m_stall;
  localparam longint STALL_MAX = (longint'(1) << CNT_W) - 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit jr, input logic [31:0] ja, input bit busy,
                               input bit ld, input logic [4:0] rd,
                               input bit r1e, input logic [4:0] r1,
                               input bit r2e, input logic [4:0] r2,
                               input logic [31:0] ia, input bit br);
    rst = r; jump_req_i = jr; jump_addr_i = ja; ex_busy_i = busy;
    ex_is_load_i = ld; ex_rd_addr_i = rd;
    id_rs1_re_i = r1e; id_rs1_addr_i = r1; id_rs2_re_i = r2e; id_rs2_addr_i = r2;
    id_inst_addr_i = ia; bus_req_i = br;
  endtask

  function automatic bit hazard();
    return ex_is_load_i && ex_rd_addr_i != 0 &&
           ((id_rs1_re_i && id_rs1_addr_i == ex_rd_addr_i) ||
            (id_rs2_re_i && id_rs2_addr_i == ex_rd_addr_i));
  endfunction

  function automatic logic [2:0] expHold();
    if (rst) return 3'd0;
    if (jump_req_i || ex_busy_i || hazard()) return 3'd3;
    return (m_draining || m_granted) ? 3'd2 : 3'd0;
  endfunction

  task automatic modelReset();
    m_draining = 0; m_granted = 0; m_progress = 0; m_stall = 0;
  endtask

  // Compare every output against the model for the current inputs.
  task automatic checkModel();
    logic        ejf;
    logic [31:0] eja;
    #1;
    if (rst) modelReset();
    ejf = 0; eja = 0;
    if (!rst) begin
      if (jump_req_i) begin ejf = 1; eja = jump_addr_i; end
      else if (!ex_busy_i && hazard()) begin ejf = 1; eja = id_inst_addr_i; end
    end
    checkOutput("hold", 32'(hold_flag_o), 32'(expHold()));
    checkOutput("jflag", 32'(jump_flag_o), 32'(ejf));
    checkOutput("jaddr", jump_addr_o, eja);
    checkOutput("gnt", 32'(bus_gnt_o), 32'(m_granted));
    checkOutput("stall", stall_cnt_o, m_stall[31:0]);
  endtask

  // Clock edge: advance the model with the inputs held across the edge.
  task automatic advance();
    logic [2:0] h;
    h = expHold();
    @(posedge clk);
    if (rst) begin
      modelReset();
    end else begin
      if (h != 0 && m_stall < STALL_MAX) m_stall++;
      if (m_granted) begin
        if (!bus_req_i) m_granted = 0;
      end else if (m_draining) begin
        if (!bus_req_i) m_draining = 0;
        else if (jump_req_i || hazard()) m_progress = 0;
        else if (!ex_busy_i) begin
          m_progress++;
          if (m_progress == DRAIN_CYCLES) begin m_draining = 0; m_granted = 1; end
        end
      end else if (bus_req_i && !jump_req_i && !ex_busy_i) begin
        m_draining = 1; m_progress = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input bit br);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, br);
  endtask

  initial begin
    modelReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkModel(); advance(); checkModel(); advance();

    // Jump at reset-idle: stall counter goes 0 -> 1
    applyStimulus(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkModel();
    checkOutput("jump_addr_const", jump_addr_o, 32'h100);
    checkOutput("jump_hold_const", 32'(hold_flag_o), 32'd3);
    checkOutput("stall_before", stall_cnt_o, 32'd0);
    advance();
    idle(0); checkModel();
    checkOutput("stall_after", stall_cnt_o, 32'd1);
    advance();

    // Load-use replay, then the same with x0 destination
    applyStimulus(0, 0, 0, 0, 1, 5'd5, 0, 0, 1, 5'd5, 32'h24, 0);
    checkModel();
    checkOutput("lu_addr", jump_addr_o, 32'h24);
    checkOutput("lu_hold", 32'(hold_flag_o), 32'd3);
    advance();
    applyStimulus(0, 0, 0, 0, 1, 5'd0, 0, 0, 1, 5'd0, 32'h24, 0);
    checkModel();
    checkOutput("lu_x0_hold", 32'(hold_flag_o), 32'd0);
    checkOutput("lu_x0_jflag", 32'(jump_flag_o), 32'd0);
    advance();

    // Jump beats load-use; busy holds for four cycles
    applyStimulus(0, 1, 32'h800, 0, 1, 5'd5, 0, 0, 1, 5'd5, 32'h24, 0);
    checkModel();
    checkOutput("prio_addr", jump_addr_o, 32'h800);
    advance();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 5'd5, 0, 0, 1, 5'd5, 32'h24, 0);
      checkModel();
      checkOutput("busy_hold", 32'(hold_flag_o), 32'd3);
      checkOutput("busy_nojump", 32'(jump_flag_o), 32'd0);
      advance();
    end

    // Clean drain: grant after the third edge, drop releases next edge
    for (int i = 0; i < 4; i++) begin
      idle(1); checkModel();
      if (i == 1) checkOutput("drain_hold", 32'(hold_flag_o), 32'd2);
      if (i == 2) checkOutput("drain_nogrant", 32'(bus_gnt_o), 32'd0);
      if (i == 3) checkOutput("grant3", 32'(bus_gnt_o), 32'd1);
      advance();
    end
    idle(0); checkModel(); advance();
    idle(0); checkModel();
    checkOutput("release_gnt", 32'(bus_gnt_o), 32'd0);
    checkOutput("release_hold", 32'(hold_flag_o), 32'd0);
    advance();

    // Jump during drain costs one extra cycle
    idle(1); checkModel(); advance();
    applyStimulus(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 1); checkModel(); advance();
    idle(1); checkModel(); advance();
    idle(1); checkModel();
    checkOutput("delay_nogrant", 32'(bus_gnt_o), 32'd0);
    advance();
    idle(1); checkModel();
    checkOutput("delay_grant", 32'(bus_gnt_o), 32'd1);

    // Asynchronous reset while granted
    #2 rst = 1;
    checkModel();
    checkOutput("async_gnt", 32'(bus_gnt_o), 32'd0);
    checkOutput("async_stall", stall_cnt_o, 32'd0);
    advance();

    // Abort mid-drain: grant never appears
    idle(1); checkModel(); advance();
    idle(0); checkModel(); advance();
    for (int i = 0; i < 4; i++) begin
      idle(0); checkModel();
      checkOutput("abort_gnt", 32'(bus_gnt_o), 32'd0);
      advance();
    end

    // Randomized traffic with a sticky bus request and small register space
    begin
      bit br = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 7) == 0) br = !br;
        applyStimulus($urandom_range(0, 299) == 0,
                      $urandom_range(0, 7) == 0, $urandom,
                      $urandom_range(0, 5) == 0,
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                      $urandom, br);
        checkModel();
        advance();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
